// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and sizing helper for the sequential divider
package div_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_div_if.sv
// seq_div_if: operand/result handshake bundle for the divider
interface seq_div_if #(parameter int N = 8);

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/rca_add.sv
// rca_add: N-bit ripple-carry adder, used with inverted b and cin=1 as a subtractor
module rca_add #(parameter int N = 9) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] c;

    assign c[0] = cin;
    assign cout = c[N];

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

endmodule

// File: rtl/seq_div.sv
// seq_div: iterative unsigned restoring divider, one quotient bit per clock
module seq_div
    import div_pkg::*;
#(
    parameter int N = 8
) (
    input  logic      clk,
    input  logic      rst,
    seq_div_if.slave  bus
);

    localparam int CW = cnt_w(N);

    div_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N:0]    r_q, r_d;
    logic [N-1:0]  q_q, q_d;
    logic [N-1:0]  dvs_q, dvs_d;
    logic [N-1:0]  quo_q, quo_d;
    logic [N-1:0]  rem_q, rem_d;
    logic          dbz_q, dbz_d;
    logic [N:0]    r_sh, t;
    logic [N-1:0]  q_sh, q_nx;
    logic          nonneg;

    assign r_sh = {r_q[N-1:0], q_q[N-1]};
    assign q_sh = q_q << 1;
    assign q_nx = q_sh | N'(nonneg);

    rca_add #(.N(N+1)) u_sub (
        .a    (r_sh),
        .b    (~{1'b0, dvs_q}),
        .cin  (1'b1),
        .sum  (t),
        .cout (nonneg)
    );

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = (state_q == DONE);
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;

    // next state: accept in IDLE, one restoring step per cycle in BUSY, hold in DONE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                dvs_d = bus.divisor;
                if (bus.divisor == '0) begin
                    state_d = DONE;
                    quo_d   = '1;
                    rem_d   = bus.dividend;
                    dbz_d   = 1'b1;
                end else begin
                    state_d = BUSY;
                    cnt_d   = CW'(N - 1);
                    r_d     = '0;
                    q_d     = bus.dividend;
                    dbz_d   = 1'b0;
                end
            end
            BUSY: begin
                r_d   = nonneg ? t : r_sh;
                q_d   = q_nx;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = DONE;
                    quo_d   = q_nx;
                    rem_d   = nonneg ? t[N-1:0] : r_sh[N-1:0];
                end
            end
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers, synchronous reset clears everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: directed table, corner sequences and random sweep for seq_div
module tb_seq_div;

    localparam int N = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    seq_div_if #(.N(N)) bus ();

    seq_div #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dbz;
        int           hold;
    } vec_t;

    vec_t tbl[10];

    function automatic logic [2*N:0] ref_div(input logic [N-1:0] a, input logic [N-1:0] b);
        if (b == 0) return {{N{1'b1}}, a, 1'b1};
        return {a / b, a % b, 1'b0};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] eq, input logic [N-1:0] er,
                         input logic ed, input int hold);
        int lat;
        chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
        bus.dividend  = a;
        bus.divisor   = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk("latency", 32'(lat), (b == 0) ? 32'd0 : 32'd8);
        chk("result", 32'({bus.quotient, bus.remainder, bus.div_by_zero}), 32'({eq, er, ed}));
        repeat (hold) begin
            bus.in_valid = 1'b1;
            bus.dividend = 8'd1;
            bus.divisor  = 8'd1;
            tick();
            chk("hold_result", 32'({bus.quotient, bus.remainder, bus.div_by_zero}), 32'({eq, er, ed}));
            chk("hold_flags", 32'({bus.out_valid, bus.in_ready}), 32'b10);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("release_flags", 32'({bus.out_valid, bus.in_ready}), 32'b01);
    endtask

    initial begin
        int cyc, done_cnt, acc_cyc;
        logic acc, rel, seen;
        logic [2*N:0] exp;

        tbl[0] = '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 0};
        tbl[1] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 0};
        tbl[2] = '{8'd3,   8'd10,  8'd0,   8'd3,   1'b0, 0};
        tbl[3] = '{8'd0,   8'd9,   8'd0,   8'd0,   1'b0, 0};
        tbl[4] = '{8'd5,   8'd0,   8'hFF,  8'd5,   1'b1, 0};
        tbl[5] = '{8'd20,  8'd4,   8'd5,   8'd0,   1'b0, 0};
        tbl[6] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 0};
        tbl[7] = '{8'd254, 8'd255, 8'd0,   8'd254, 1'b0, 0};
        tbl[8] = '{8'd128, 8'd3,   8'd42,  8'd2,   1'b0, 2};
        tbl[9] = '{8'd200, 8'd13,  8'd15,  8'd5,   1'b0, 5};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        chk("reset_flags", 32'({bus.out_valid, bus.in_ready}), 32'b01);
        chk("reset_outputs", 32'({bus.quotient, bus.remainder, bus.div_by_zero}), 32'd0);

        for (int i = 0; i < 10; i++)
            do_op(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dbz, tbl[i].hold);

        bus.dividend = 8'd200;
        bus.divisor  = 8'd13;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_flags", 32'({bus.out_valid, bus.in_ready}), 32'b01);
        chk("midrst_outputs", 32'({bus.quotient, bus.remainder, bus.div_by_zero}), 32'd0);
        repeat (10) tick();
        chk("midrst_no_result", 32'({bus.out_valid, bus.in_ready}), 32'b01);
        do_op(8'd9, 8'd2, 8'd4, 8'd1, 1'b0, 0);

        cyc = 0;
        done_cnt = 0;
        acc_cyc = 0;
        seen = 1'b1;
        exp = '0;
        bus.in_valid = 1'b1;
        bus.dividend = 8'($urandom);
        bus.divisor  = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
        while (done_cnt < 1000 && cyc < 30000) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            if (bus.out_valid && !seen) begin
                seen = 1'b1;
                chk("rand_latency", 32'(cyc - acc_cyc), exp[0] ? 32'd0 : 32'd8);
            end
            acc = bus.in_ready && bus.in_valid;
            rel = bus.out_valid && bus.out_ready;
            if (rel) begin
                chk("rand_result", 32'({bus.quotient, bus.remainder, bus.div_by_zero}), 32'(exp));
                done_cnt++;
            end
            if (acc) exp = ref_div(bus.dividend, bus.divisor);
            tick();
            cyc++;
            if (acc) begin
                acc_cyc = cyc;
                seen = 1'b0;
                chk("rand_one_accept", 32'(bus.in_ready), 32'd0);
            end
            bus.dividend = 8'($urandom);
            bus.divisor  = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
        end
        bus.in_valid = 1'b0;
        if (done_cnt < 1000) begin
            miscompares++;
            $display("FAIL rand_timeout: completed %0d ops, needed 1000", done_cnt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
